// File: rtl/spartan_memory.sv
// spartan_memory: unified 16-bit word store shared by the CPU data and
// instruction sides. One write port (from the shared bus) and two read
// registers. The CPU steers all bus turnaround through the push enables.
module spartan_memory #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_read,
    input  logic        d_write,
    input  logic        d_push,
    input  logic        i_read,
    input  logic        i_push,
    input  logic [15:0] d_addr,
    input  logic [15:0] i_addr,
    inout  wire  [15:0] d_bus
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // Contents start at zero in simulation and are never touched by rst.
    logic [15:0] mem [DEPTH] = '{default: 16'h0000};

    logic [15:0] d_reg;
    logic [15:0] i_reg;

    // Only the low address bits select a word; upper bits alias.
    logic [ADDR_BITS-1:0] d_idx;
    logic [ADDR_BITS-1:0] i_idx;
    assign d_idx = d_addr[ADDR_BITS-1:0];
    assign i_idx = i_addr[ADDR_BITS-1:0];

    // Write port: captures the externally driven bus; suppressed during reset.
    always_ff @(posedge clk) begin
        if (!rst && d_write)
            mem[d_idx] <= d_bus;
    end

    // Read registers: non-blocking reads return pre-write contents on a
    // same-address collision, and both sides may read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg <= 16'h0000;
            i_reg <= 16'h0000;
        end else begin
            if (d_read)
                d_reg <= mem[d_idx];
            if (i_read)
                i_reg <= mem[i_idx];
        end
    end

    // Bus drive: a write always releases the bus; data register beats
    // instruction register so at most one internal driver is ever on.
    assign d_bus = d_write ? 16'hzzzz :
                   d_push  ? d_reg    :
                   i_push  ? i_reg    :
                             16'hzzzz;

endmodule

// File: tb/tb_spartan_memory.sv
// Self-checking bench for spartan_memory: directed scenarios followed by a
// randomized run against a word-level reference model.
module tb_spartan_memory;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        d_read = 1'b0, d_write = 1'b0, d_push = 1'b0;
    logic        i_read = 1'b0, i_push = 1'b0;
    logic [15:0] d_addr = '0, i_addr = '0;
    logic        drv_en = 1'b0;
    logic [15:0] drv_data = '0;
    wire  [15:0] d_bus;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_d = '0;
    logic [15:0] m_i = '0;

    always #5 clk = ~clk;

    // External (CPU-side) driver; a released bus is pulled up to all ones.
    assign d_bus = drv_en ? drv_data : 16'hzzzz;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup pu (d_bus[g]);
    end

    spartan_memory #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst),
        .d_read(d_read), .d_write(d_write), .d_push(d_push),
        .i_read(i_read), .i_push(i_push),
        .d_addr(d_addr), .i_addr(i_addr),
        .d_bus(d_bus)
    );

    // Expected bus value from the model and the current enables.
    function automatic logic [15:0] exp_bus();
        if (d_write) return drv_en ? drv_data : 16'hFFFF;
        if (d_push)  return m_d;
        if (i_push)  return m_i;
        return 16'hFFFF;
    endfunction

    // One clock edge; the model applies the same edge from the held inputs.
    task automatic tick();
        logic [15:0] nd, ni;
        @(posedge clk);
        if (rst) begin
            m_d = '0;
            m_i = '0;
        end else begin
            nd = m_d;
            ni = m_i;
            if (d_read) nd = m_mem[d_addr % DEPTH];
            if (i_read) ni = m_mem[i_addr % DEPTH];
            if (d_write) m_mem[d_addr % DEPTH] = drv_en ? drv_data : 16'hFFFF;
            m_d = nd;
            m_i = ni;
        end
        #1;
    endtask

    task automatic idle();
        d_read = 0; d_write = 0; d_push = 0; i_read = 0; i_push = 0;
        drv_en = 0; rst = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        idle();
        d_addr = a; drv_data = v; drv_en = 1; d_write = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        d_push = 1; #1;
        checks++;
        if (d_bus !== 16'h0000) begin errors++; $display("FAIL reset_d_reg: got %h want 0000", d_bus); end
        d_push = 0; i_push = 1; #1;
        checks++;
        if (d_bus !== 16'h0000) begin errors++; $display("FAIL reset_i_reg: got %h want 0000", d_bus); end
        i_push = 0; #1;
        checks++;
        if (d_bus !== 16'hFFFF) begin errors++; $display("FAIL reset_idle_release: got %h want ffff", d_bus); end
    endtask

    task automatic test_write_read();
        idle();
        d_addr = 16'd3; drv_data = 16'd47; drv_en = 1; d_write = 1;
        d_push = 1; #1;
        checks++;
        if (d_bus !== 16'd47) begin errors++; $display("FAIL write_bus_release: got %h want %h", d_bus, 16'd47); end
        tick();
        idle();
        d_read = 1;
        tick();
        d_read = 0; d_push = 1; #1;
        checks++;
        if (d_bus !== 16'd47) begin errors++; $display("FAIL write_then_read: got %h want %h", d_bus, 16'd47); end
        d_push = 0; #1;
        checks++;
        if (d_bus !== 16'hFFFF) begin errors++; $display("FAIL idle_hiz: got %h want ffff", d_bus); end
    endtask

    task automatic test_instr();
        wr(16'd5, 16'h1234);
        i_addr = 16'd5; i_read = 1;
        tick();
        i_read = 0; i_push = 1; #1;
        checks++;
        if (d_bus !== 16'h1234) begin errors++; $display("FAIL instr_read: got %h want 1234", d_bus); end
        i_push = 0; d_push = 1; #1;
        checks++;
        if (d_bus !== 16'd47) begin errors++; $display("FAIL instr_keeps_d_reg: got %h want %h", d_bus, 16'd47); end
        idle();
    endtask

    task automatic test_priority();
        idle();
        d_push = 1; i_push = 1; #1;
        checks++;
        if (d_bus !== 16'd47) begin errors++; $display("FAIL push_priority: got %h want %h", d_bus, 16'd47); end
        d_write = 1; drv_data = 16'hBEEF; drv_en = 1; #1;
        checks++;
        if (d_bus !== 16'hBEEF) begin errors++; $display("FAIL write_overrides_push: got %h want beef", d_bus); end
        // Drop the write before any edge so memory is untouched.
        d_write = 0; drv_en = 0; #1;
        checks++;
        if (d_bus !== 16'd47) begin errors++; $display("FAIL push_after_write_drop: got %h want %h", d_bus, 16'd47); end
        idle();
    endtask

    task automatic test_rdw();
        wr(16'd7, 16'h0011);
        d_addr = 16'd7; drv_data = 16'h0022; drv_en = 1; d_write = 1; d_read = 1;
        tick();
        idle();
        d_push = 1; #1;
        checks++;
        if (d_bus !== 16'h0011) begin errors++; $display("FAIL rdw_d_old: got %h want 0011", d_bus); end
        d_push = 0; d_read = 1;
        tick();
        d_read = 0; d_push = 1; #1;
        checks++;
        if (d_bus !== 16'h0022) begin errors++; $display("FAIL rdw_d_new: got %h want 0022", d_bus); end
        idle();
        i_addr = 16'd7; i_read = 1; d_addr = 16'd7; drv_data = 16'h0033; drv_en = 1; d_write = 1;
        tick();
        idle();
        i_push = 1; #1;
        checks++;
        if (d_bus !== 16'h0022) begin errors++; $display("FAIL rdw_i_old: got %h want 0022", d_bus); end
        idle();
    endtask

    task automatic test_alias_reset();
        wr(16'd3, 16'h00AA);
        d_addr = 16'd3 + 16'd1024; d_read = 1;
        tick();
        d_read = 0; d_push = 1; #1;
        checks++;
        if (d_bus !== 16'h00AA) begin errors++; $display("FAIL alias_read: got %h want 00aa", d_bus); end
        idle();
        i_addr = 16'd5; i_read = 1;
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0; d_push = 1; #1;
        checks++;
        if (d_bus !== 16'h0000) begin errors++; $display("FAIL rst_clears_d: got %h want 0000", d_bus); end
        d_push = 0; i_push = 1; #1;
        checks++;
        if (d_bus !== 16'h0000) begin errors++; $display("FAIL rst_clears_i: got %h want 0000", d_bus); end
        idle();
        d_addr = 16'd3; d_read = 1;
        tick();
        d_read = 0; d_push = 1; #1;
        checks++;
        if (d_bus !== 16'h00AA) begin errors++; $display("FAIL mem_survives_rst: got %h want 00aa", d_bus); end
        idle();
    endtask

    task automatic test_continuous();
        idle();
        d_addr = 16'd7; d_read = 1; d_push = 1;
        tick();
        checks++;
        if (d_bus !== 16'h0033) begin errors++; $display("FAIL track_first: got %h want 0033", d_bus); end
        d_addr = 16'd3; #1;
        checks++;
        if (d_bus !== 16'h0033) begin errors++; $display("FAIL track_lag_3: got %h want 0033", d_bus); end
        tick();
        checks++;
        if (d_bus !== 16'h00AA) begin errors++; $display("FAIL track_3: got %h want 00aa", d_bus); end
        d_addr = 16'd5; #1;
        checks++;
        if (d_bus !== 16'h00AA) begin errors++; $display("FAIL track_lag_5: got %h want 00aa", d_bus); end
        tick();
        checks++;
        if (d_bus !== 16'h1234) begin errors++; $display("FAIL track_5: got %h want 1234", d_bus); end
        idle();
    endtask

    task automatic test_random();
        logic [15:0] exp;
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 24) == 0);
            d_write = ($urandom_range(0, 2) == 0);
            drv_en  = d_write;
            drv_data = 16'($urandom);
            d_read  = 1'($urandom);
            i_read  = 1'($urandom);
            d_push  = 1'($urandom);
            i_push  = 1'($urandom);
            d_addr  = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 63)) << 10);
            i_addr  = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 63)) << 10);
            #1;
            exp = exp_bus();
            checks++;
            if (d_bus !== exp) begin
                errors++;
                $display("FAIL random_bus[%0d]: got %h want %h", n, d_bus, exp);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 16'h0000;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_instr();
        test_priority();
        test_rdw();
        test_alias_reset();
        test_continuous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
